// File: rtl/sync_fifo_flags.sv
// Synchronous FWFT FIFO with level, almost-full/empty thresholds and optional sticky errors.
// Define SYNC_FIFO_ERR_FLAGS_EN to build the overflow/underflow flag registers.
module sync_fifo_flags #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 4,
  parameter int AFULL_TH  = DEPTH - 1,
  parameter int AEMPTY_TH = 1
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  input  logic                       flush,
  input  logic                       err_clr,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_AFULL = LW'(AFULL_TH);
  localparam logic [LW-1:0] LVL_AEMPT = LW'(AEMPTY_TH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // Handshake: pop is accepted whenever the FIFO holds data; push is accepted when
  // there is room or a same-cycle accepted pop frees one. Rejected requests are
  // dropped, never held over to a later cycle.
  always_comb begin
    pop_ok  = pop & ~empty;
    push_ok = push & (~full | pop_ok);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; stale contents are hidden by the empty mask on dout.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= din;
  end

  always_comb begin
    level        = count;
    full         = (count == LVL_FULL);
    empty        = (count == '0);
    almost_full  = (count >= LVL_AFULL);
    almost_empty = (count <= LVL_AEMPT);
    dout         = empty ? '0 : mem[rd_ptr];
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic ovf_q;
  logic udf_q;
  logic ovf_set;
  logic udf_set;

  always_comb begin
    ovf_set = push & ~push_ok & ~flush;
    udf_set = pop & empty & ~flush;
  end

  // A new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (ovf_set)      ovf_q <= 1'b1;
      else if (err_clr) ovf_q <= 1'b0;
      if (udf_set)      udf_q <= 1'b1;
      else if (err_clr) udf_q <= 1'b0;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = udf_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule

// File: doc/sync_fifo_flags.md
SYNC_FIFO_FLAGS -- requirements
Module: sync_fifo_flags

Interface
REQ-001 Parameter WIDTH, default 32, data bit width (>=1).
REQ-002 Parameter DEPTH, default 4, entries (>=2, non-power-of-two legal).
REQ-003 Parameter AFULL_TH, default DEPTH-1, almost_full threshold (1..DEPTH).
REQ-004 Parameter AEMPTY_TH, default 1, almost_empty threshold (0..DEPTH-1).
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rstn  input  1  reset, asynchronous assert, active-low.
REQ-007 push  input  1  write request.
REQ-008 din  input  WIDTH  write data.
REQ-009 pop  input  1  read request; consumes the entry currently on dout.
REQ-010 dout  output  WIDTH  FWFT head entry.
REQ-011 flush  input  1  synchronous discard of all contents.
REQ-012 err_clr  input  1  clears sticky error flags.
REQ-013 full, empty  output  1 each  occupancy status.
REQ-014 almost_full, almost_empty  output  1 each  threshold status.
REQ-015 level  output  $clog2(DEPTH+1)  current entry count.
REQ-016 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-017 All outputs SHALL be derived from registered state only; no input-to-output combinational path.
REQ-018 push_ok = push & (!full | (pop & !empty)); pop_ok = pop & !empty; full with simultaneous push+pop SHALL accept both, level unchanged.
REQ-019 push_ok SHALL write din at wr_ptr and advance wr_ptr; pop_ok SHALL advance rd_ptr; pointers SHALL wrap from DEPTH-1 to 0 for any DEPTH.
REQ-020 level SHALL update +1 (push_ok only), -1 (pop_ok only), else hold; never exceeds DEPTH or underflows 0.
REQ-021 full = (level==DEPTH); empty = (level==0); almost_full = (level>=AFULL_TH); almost_empty = (level<=AEMPTY_TH).
REQ-022 dout SHALL equal mem[rd_ptr] when !empty, and all-zero when empty.
REQ-023 Push into empty FIFO SHALL present data on dout the cycle after the push edge (1-cycle write-to-read latency); push+pop while empty SHALL accept the push only.
REQ-024 flush SHALL, at the next edge, set wr_ptr=rd_ptr=level=0, overriding push and pop in that cycle (both discarded, not counted as errors).
REQ-025 Storage array SHALL not be reset; contents after flush/reset are undefined but masked by REQ-022.

Reset
REQ-026 rstn low SHALL immediately force wr_ptr=rd_ptr=level=0, overflow=underflow=0.
REQ-027 Resulting outputs: empty=1, full=0, level=0, dout=0, almost_empty=1, almost_full=0 (AFULL_TH>=1).
REQ-028 Reset asserted mid-operation SHALL abandon in-flight push/pop; first accepted push after rstn release lands in entry 0.

Configuration
REQ-029 Macro SYNC_FIFO_ERR_FLAGS_EN defined: overflow sets on push & !push_ok & !flush; underflow sets on pop & empty & !flush; both sticky until err_clr; set SHALL win over simultaneous err_clr.
REQ-030 Macro undefined: overflow and underflow SHALL be constant 0, err_clr ignored, no flag registers built; all other behaviour identical.

Verification
REQ-031 WIDTH=8, DEPTH=5, AFULL_TH=4, AEMPTY_TH=1: push 0x11..0x15 over 5 cycles -> level 1..5, almost_full at level 4, full at 5, dout=0x11 throughout.
REQ-032 Same config, full, push 0x66 + pop together -> dout becomes 0x12, level stays 5, 0x66 read out last after 0x12..0x15; wr/rd pointer wrap exercised.
REQ-033 Full, push 0x77 alone (flags enabled) -> overflow=1, level 5, data unchanged; err_clr pulse -> overflow=0 next cycle; err_clr with new overflow same cycle -> overflow stays 1.
REQ-034 Empty, pop -> underflow=1, dout=0, level 0; empty, push 0xA5 + pop -> level 1, dout=0xA5 next cycle, underflow unchanged by that pop (counted only per REQ-029).
REQ-035 Level 3, flush with push 0x99 + pop -> next cycle level 0, empty=1, dout=0, no error flag set; following push 0x42 -> dout=0x42.
REQ-036 Level 3, assert rstn low between edges -> outputs per REQ-027 immediately; after release, push 0x01 -> dout=0x01, level 1; macro undefined build: REQ-033/034 stimulus -> overflow=underflow=0.
